// File: rtl/snn_pkg.sv
// snn_pkg: shared types, default sizes and the saturating adder for the spiking layer scheduler.
package snn_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, ISSUE, DONE} sched_state_e;
   localparam int SNN_LAYER_SIZE    = 4;
   localparam int SNN_WEIGHT_WIDTH  = 8;
   localparam int SNN_CURRENT_WIDTH = 10;
   // a + b clipped to the largest value representable in cw bits
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int cw);
      logic [32:0] s;
      logic [31:0] lim;
      lim = (32'd1 << cw) - 32'd1;
      s   = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, lim}) ? lim : s[31:0];
   endfunction
endpackage

// File: rtl/snn_weight_regfile.sv
// snn_weight_regfile: square weight matrix, synchronous write, combinational read, async clear.
module snn_weight_regfile
   import snn_pkg::*;
#(
   parameter int LAYER_SIZE   = SNN_LAYER_SIZE,
   parameter int WEIGHT_WIDTH = SNN_WEIGHT_WIDTH,
   localparam int AW = (LAYER_SIZE > 1) ? $clog2(LAYER_SIZE) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we_i,
   input  logic [AW-1:0]           wrow_i,
   input  logic [AW-1:0]           wcol_i,
   input  logic [WEIGHT_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]           rrow_i,
   input  logic [AW-1:0]           rcol_i,
   output logic [WEIGHT_WIDTH-1:0] rdata_o
);
   logic [WEIGHT_WIDTH-1:0] w_q [LAYER_SIZE][LAYER_SIZE];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < LAYER_SIZE; r++)
            for (int c = 0; c < LAYER_SIZE; c++)
               w_q[r][c] <= '0;
      end else if (we_i) begin
         w_q[wrow_i][wcol_i] <= wdata_i;
      end
   end
   assign rdata_o = w_q[rrow_i][rcol_i];
endmodule

// File: rtl/snn_layer_scheduler.sv
// snn_layer_scheduler: serial accumulate-and-issue controller for one fully connected spiking layer.
module snn_layer_scheduler
   import snn_pkg::*;
#(
   parameter int LAYER_SIZE    = SNN_LAYER_SIZE,
   parameter int WEIGHT_WIDTH  = SNN_WEIGHT_WIDTH,
   parameter int CURRENT_WIDTH = SNN_CURRENT_WIDTH,
   localparam int AW = (LAYER_SIZE > 1) ? $clog2(LAYER_SIZE) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [LAYER_SIZE-1:0]    in_spikes_i,
   input  logic                     cfg_we_i,
   input  logic [AW-1:0]            cfg_row_i,
   input  logic [AW-1:0]            cfg_col_i,
   input  logic [WEIGHT_WIDTH-1:0]  cfg_wdata_i,
   output logic                     cfg_err_o,
   output logic                     cur_valid_o,
   output logic [AW-1:0]            cur_idx_o,
   output logic [CURRENT_WIDTH-1:0] cur_data_o,
   output logic                     cur_sat_o,
   output logic                     step_done_o
);
   if (CURRENT_WIDTH < WEIGHT_WIDTH) begin : g_width_check
      $error("CURRENT_WIDTH must be >= WEIGHT_WIDTH");
   end
   sched_state_e            state_q, state_d;
   logic [AW-1:0]           n_q, n_d, c_q, c_d;
   logic [CURRENT_WIDTH:0]  acc_q, acc_d;
   logic                    sat_q, sat_d;
   logic [LAYER_SIZE-1:0]   spikes_q;
   logic                    cfg_err_q;
   logic [WEIGHT_WIDTH-1:0] w_rd, add_w;
   logic [31:0]             raw_w, sum_w;
   logic                    idle;
   assign idle = (state_q == IDLE);
   snn_weight_regfile #(
      .LAYER_SIZE  (LAYER_SIZE),
      .WEIGHT_WIDTH(WEIGHT_WIDTH)
   ) u_wrf (
      .clk    (clk),
      .rst    (rst),
      .we_i   (cfg_we_i && idle),
      .wrow_i (cfg_row_i),
      .wcol_i (cfg_col_i),
      .wdata_i(cfg_wdata_i),
      .rrow_i (n_q),
      .rcol_i (c_q),
      .rdata_o(w_rd)
   );
   assign add_w = spikes_q[c_q] ? w_rd : '0;
   assign raw_w = 32'(acc_q) + 32'(add_w);
   assign sum_w = sat_add(32'(acc_q), 32'(add_w), CURRENT_WIDTH);
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      c_d     = c_q;
      acc_d   = acc_q;
      sat_d   = sat_q;
      case (state_q)
         IDLE: begin
            state_d = in_valid_i ? ACCUM : IDLE;
            n_d     = '0;
            c_d     = '0;
         end
         ACCUM: begin
            acc_d   = sum_w[CURRENT_WIDTH:0];
            sat_d   = sat_q | (sum_w != raw_w);
            c_d     = c_q + AW'(1);
            state_d = (c_q == AW'(LAYER_SIZE - 1)) ? ISSUE : ACCUM;
         end
         ISSUE: begin
            acc_d   = '0;
            sat_d   = 1'b0;
            c_d     = '0;
            state_d = (n_q == AW'(LAYER_SIZE - 1)) ? DONE : ACCUM;
            n_d     = (n_q == AW'(LAYER_SIZE - 1)) ? n_q : n_q + AW'(1);
         end
         default: begin
            state_d = IDLE;
            n_d     = '0;
         end
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         n_q       <= '0;
         c_q       <= '0;
         acc_q     <= '0;
         sat_q     <= 1'b0;
         spikes_q  <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         c_q       <= c_d;
         acc_q     <= acc_d;
         sat_q     <= sat_d;
         spikes_q  <= (idle && in_valid_i) ? in_spikes_i : spikes_q;
         cfg_err_q <= cfg_we_i && !idle;
      end
   end
   // acc never exceeds the CURRENT_WIDTH limit, so its top bit is always clear here
   assign in_ready_o  = idle;
   assign cfg_err_o   = cfg_err_q;
   assign cur_valid_o = (state_q == ISSUE);
   assign cur_idx_o   = n_q;
   assign cur_data_o  = acc_q[CURRENT_WIDTH-1:0];
   assign cur_sat_o   = sat_q;
   assign step_done_o = (state_q == DONE);
endmodule

// File: tb/tb_snn_layer_scheduler.sv
// tb_snn_layer_scheduler: directed and random timesteps on 10-bit and 9-bit current instances vs a sum-and-clip model.
module tb_snn_layer_scheduler;
   localparam int L = 4;
   localparam int P = L + 1;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_spikes;
   logic       cfg_we;
   logic [1:0] cfg_row, cfg_col;
   logic [7:0] cfg_wdata;
   logic       rdy_a, err_a, val_a, sat_a, done_a;
   logic [1:0] idx_a;
   logic [9:0] dat_a;
   logic       rdy_b, err_b, val_b, sat_b, done_b;
   logic [1:0] idx_b;
   logic [8:0] dat_b;
   int         checks = 0;
   int         errors = 0;
   int         wm [L][L];

   always #5 clk = ~clk;

   snn_layer_scheduler #(.LAYER_SIZE(4), .WEIGHT_WIDTH(8), .CURRENT_WIDTH(10)) dut_a (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy_a), .in_spikes_i(in_spikes),
      .cfg_we_i(cfg_we), .cfg_row_i(cfg_row), .cfg_col_i(cfg_col), .cfg_wdata_i(cfg_wdata),
      .cfg_err_o(err_a), .cur_valid_o(val_a), .cur_idx_o(idx_a), .cur_data_o(dat_a),
      .cur_sat_o(sat_a), .step_done_o(done_a));

   snn_layer_scheduler #(.LAYER_SIZE(4), .WEIGHT_WIDTH(8), .CURRENT_WIDTH(9)) dut_b (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy_b), .in_spikes_i(in_spikes),
      .cfg_we_i(cfg_we), .cfg_row_i(cfg_row), .cfg_col_i(cfg_col), .cfg_wdata_i(cfg_wdata),
      .cfg_err_o(err_b), .cur_valid_o(val_b), .cur_idx_o(idx_b), .cur_data_o(dat_b),
      .cur_sat_o(sat_b), .step_done_o(done_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " rdy_a"}, 32'(rdy_a), 1);
      chk({tag, " rdy_b"}, 32'(rdy_b), 1);
      chk({tag, " val_a"}, 32'(val_a), 0);
      chk({tag, " val_b"}, 32'(val_b), 0);
      chk({tag, " done_a"}, 32'(done_a), 0);
      chk({tag, " err_a"}, 32'(err_a), 0);
      chk({tag, " idx_a"}, 32'(idx_a), 0);
      chk({tag, " dat_a"}, 32'(dat_a), 0);
      chk({tag, " sat_a"}, 32'(sat_a), 0);
      chk({tag, " dat_b"}, 32'(dat_b), 0);
      chk({tag, " sat_b"}, 32'(sat_b), 0);
   endtask

   task automatic wr(input int r, input int c, input int d);
      cfg_we = 1'b1;
      cfg_row = 2'(r);
      cfg_col = 2'(c);
      cfg_wdata = 8'(d);
      tick();
      cfg_we = 1'b0;
      wm[r][c] = d;
   endtask

   // One timestep. err_k: cycle carrying a rejected cfg write; rst_k: cycle where reset aborts the step;
   // hold/nxt: keep in_valid high with the next vector while busy; wr0: write w[0][0]=99 with acceptance.
   task automatic run_step(input logic [3:0] sp, input logic [3:0] nxt, input bit hold,
                           input int err_k, input int rst_k, input bit wr0);
      int sum [L];
      string t;
      if (wr0) begin
         cfg_we = 1'b1; cfg_row = 2'd0; cfg_col = 2'd0; cfg_wdata = 8'd99;
         wm[0][0] = 99;
      end
      for (int n = 0; n < L; n++) begin
         sum[n] = 0;
         for (int c = 0; c < L; c++) sum[n] += sp[c] ? wm[n][c] : 0;
      end
      in_valid = 1'b1;
      in_spikes = sp;
      chk("accept rdy_a", 32'(rdy_a), 1);
      chk("accept rdy_b", 32'(rdy_b), 1);
      tick();
      cfg_we = 1'b0;
      in_valid = hold;
      in_spikes = nxt;
      for (int k = 1; k <= 22; k++) begin
         if (k == rst_k) begin
            rst = 1'b1;
            in_valid = 1'b0;
            #1;
            chk_reset_outputs($sformatf("abort k%0d", k));
            for (int j = 0; j < 3; j++) begin
               tick();
               chk("abort val_a", 32'(val_a), 0);
               chk("abort done_a", 32'(done_a), 0);
               chk("abort done_b", 32'(done_b), 0);
            end
            rst = 1'b0;
            for (int r = 0; r < L; r++)
               for (int c = 0; c < L; c++) wm[r][c] = 0;
            tick();
            chk("after abort rdy_a", 32'(rdy_a), 1);
            chk("after abort val_a", 32'(val_a), 0);
            return;
         end
         t = $sformatf("k%0d", k);
         chk({t, " val_a"}, 32'(val_a), 32'(k % P == 0 && k <= L * P));
         chk({t, " val_b"}, 32'(val_b), 32'(k % P == 0 && k <= L * P));
         chk({t, " done_a"}, 32'(done_a), 32'(k == L * P + 1));
         chk({t, " done_b"}, 32'(done_b), 32'(k == L * P + 1));
         chk({t, " rdy_a"}, 32'(rdy_a), 32'(k == L * P + 2));
         chk({t, " err_a"}, 32'(err_a), 32'(k == err_k + 1));
         chk({t, " err_b"}, 32'(err_b), 32'(k == err_k + 1));
         if (k % P == 0 && k <= L * P) begin
            chk({t, " idx_a"}, 32'(idx_a), k / P - 1);
            chk({t, " idx_b"}, 32'(idx_b), k / P - 1);
            chk({t, " dat_a"}, 32'(dat_a), (sum[k/P-1] > 1023) ? 1023 : sum[k/P-1]);
            chk({t, " sat_a"}, 32'(sat_a), 32'(sum[k/P-1] > 1023));
            chk({t, " dat_b"}, 32'(dat_b), (sum[k/P-1] > 511) ? 511 : sum[k/P-1]);
            chk({t, " sat_b"}, 32'(sat_b), 32'(sum[k/P-1] > 511));
         end
         if (k == err_k) begin
            cfg_we = 1'b1; cfg_row = 2'd0; cfg_col = 2'd0; cfg_wdata = 8'd99;
         end
         if (k < 22) tick();
         cfg_we = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_spikes = '0;
      cfg_we = 1'b0;
      cfg_row = '0;
      cfg_col = '0;
      cfg_wdata = '0;
      for (int r = 0; r < L; r++)
         for (int c = 0; c < L; c++) wm[r][c] = 0;
      @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      tick();
      run_step(4'b1111, 4'b0000, 1'b0, -1, -1, 1'b0);
      for (int r = 0; r < L; r++)
         for (int c = 0; c < L; c++) wr(r, c, 10 * r + c + 1);
      run_step(4'b0101, 4'b0000, 1'b0, -1, -1, 1'b0);
      run_step(4'b1111, 4'b0000, 1'b0, 7, -1, 1'b0);
      run_step(4'b0001, 4'b0000, 1'b0, -1, -1, 1'b1);
      for (int r = 0; r < L; r++)
         for (int c = 0; c < L; c++) wr(r, c, 255);
      run_step(4'b1111, 4'b0000, 1'b0, -1, -1, 1'b0);
      wr(2, 1, 3);
      run_step(4'b0011, 4'b1100, 1'b1, -1, -1, 1'b0);
      run_step(4'b1100, 4'b0000, 1'b0, -1, -1, 1'b0);
      for (int it = 0; it < 4; it++) begin
         for (int r = 0; r < L; r++)
            for (int c = 0; c < L; c++) wr(r, c, int'($urandom_range(0, 255)));
         run_step(4'($urandom_range(0, 15)), 4'b0000, 1'b0, -1, -1, 1'b0);
      end
      run_step(4'b1111, 4'b0000, 1'b0, -1, 12, 1'b0);
      run_step(4'b1111, 4'b0000, 1'b0, -1, -1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
